// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_pkg
//  Brief    : Shared types and default constants for the NTT datapath
//             (loader FSM states, default geometry, lane-index width).
//  Revision : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  // Default polynomial geometry
  localparam int c_DEFAULT_BN     = 16;
  localparam int c_DEFAULT_DEGREE = 1024;

  // Width of a lane index within one row for the default bank count
  localparam int c_LANE_W = $clog2(c_DEFAULT_BN);

  // Loader control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/mod_cond_sub.sv
`default_nettype none
// ============================================================================
//  Module   : mod_cond_sub
//  Brief    : Combinational single conditional subtraction, y = x mod q,
//             valid only for x < 2q. Shared with the butterfly units.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_cond_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_y
);

  // One subtraction suffices because the input is below 2q
  assign o_y = (i_x >= i_q) ? (i_x - i_q) : i_x;

endmodule
`default_nettype wire

// File: rtl/ntt_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_coef_loader
//  Brief    : Serial coefficient intake for the NTT core. Packs BN
//             consecutive coefficients into one row and writes it to the
//             BN-bank coefficient memory; pulses load_done after the last row.
//             Optional define NTT_LOADER_MOD_REDUCE_EN reduces each accepted
//             coefficient once against modulus before storage.
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_coef_loader
  import ntt_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int DEGREE  = c_DEFAULT_DEGREE,
  parameter int BN      = c_DEFAULT_BN,
  parameter int MA      = DEGREE / BN,
  parameter int AW      = $clog2(MA)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [D_WIDTH-1:0]    modulus,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [D_WIDTH-1:0]    in_data,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [BN*D_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  load_done
);

  localparam int              c_LW       = (BN > 1) ? $clog2(BN) : 1;
  localparam logic [c_LW-1:0] c_LANE_MAX = c_LW'(BN - 1);
  localparam logic [AW-1:0]   c_ROW_MAX  = AW'(MA - 1);

  loader_state_t                r_state;
  loader_state_t                w_state_next;
  logic [c_LW-1:0]              r_lane;
  logic [AW-1:0]                r_row;
  logic [BN-1:0][D_WIDTH-1:0]   r_buf;
  logic [BN-1:0][D_WIDTH-1:0]   r_wr_data;
  logic [BN-1:0][D_WIDTH-1:0]   w_row;
  logic [AW-1:0]                r_wr_addr;
  logic                         r_wr_en;
  logic                         r_load_done;
  logic                         w_beat;
  logic                         w_row_end;
  logic                         w_last_row;
  logic [D_WIDTH-1:0]           w_coef;

`ifdef NTT_LOADER_MOD_REDUCE_EN
  mod_cond_sub #(
    .WIDTH (D_WIDTH)
  ) u_mod_cond_sub (
    .i_x (in_data),
    .i_q (modulus),
    .o_y (w_coef)
  );
`else
  logic w_unused_modulus;
  assign w_coef           = in_data;
  assign w_unused_modulus = ^modulus;
`endif

  assign in_ready   = (r_state == LOAD);
  assign busy       = (r_state == LOAD);
  assign w_beat     = in_valid && in_ready;
  assign w_row_end  = w_beat && (r_lane == c_LANE_MAX);
  assign w_last_row = (r_row == c_ROW_MAX);

  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign load_done   = r_load_done;

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: start only honoured in IDLE; final row end moves to DONE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LOAD;
      LOAD:    if (w_row_end && w_last_row) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Completed row: buffered lanes plus the current beat in the top lane
  always_comb begin
    w_row         = r_buf;
    w_row[BN-1]   = w_coef;
  end

  // Lane/row counters, row buffer and registered memory write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane      <= '0;
      r_row       <= '0;
      r_buf       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_wr_en     <= w_row_end;
      r_load_done <= (r_state == DONE);
      if (r_state == IDLE && start) begin
        r_lane <= '0;
        r_row  <= '0;
      end else if (w_beat) begin
        r_buf[r_lane] <= w_coef;
        r_lane        <= w_row_end ? '0 : r_lane + 1'b1;
        if (w_row_end) begin
          r_row     <= r_row + 1'b1;
          r_wr_addr <= r_row;
          r_wr_data <= w_row;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_coef_loader
//  Brief    : Directed self-checking bench for ntt_coef_loader: timing of
//             row writes and load_done, packing under valid gaps, ignored
//             start pulses, mid-load reset, IDLE behaviour, back-to-back
//             loads and the optional modular reduction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_coef_loader;

  localparam int DW  = 32;
  localparam int BN  = 16;
  localparam int DEG = 1024;
  localparam int MA  = DEG / BN;
  localparam int AW  = $clog2(MA);

  logic              clk;
  logic              rst;
  logic [DW-1:0]     modulus;
  logic              start;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [BN*DW-1:0]  mem_wr_data;
  logic              busy;
  logic              load_done;

  ntt_coef_loader #(
    .D_WIDTH (DW),
    .DEGREE  (DEG),
    .BN      (BN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .modulus     (modulus),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .load_done   (load_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int beats = 0;
  int ready_bad = 0;

  // Write/done log captured by the monitor
  logic [AW-1:0]    wa_q[$];
  logic [BN*DW-1:0] wd_q[$];
  int               wc_q[$];
  int               wb_q[$];
  int               done_q[$];

  // Special inputs and their hand-reduced values for modulus 65537
  int sp_in[4] = '{65536, 65537, 65538, 131073};
`ifdef NTT_LOADER_MOD_REDUCE_EN
  int sp_exp[4] = '{65536, 0, 1, 65536};
`else
  int sp_exp[4] = '{65536, 65537, 65538, 131073};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wa_q.push_back(mem_wr_addr);
      wd_q.push_back(mem_wr_data);
      wc_q.push_back(cyc);
      wb_q.push_back(beats);
    end
    if (load_done) done_q.push_back(cyc);
    if (busy && !in_ready) ready_bad <= ready_bad + 1;
    if (in_valid && in_ready) beats <= beats + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int coef_in(input int n, input int base, input bit special);
    if (special && n < 4) return sp_in[n];
    return base + n;
  endfunction

  function automatic int coef_exp(input int n, input int base, input bit special);
    if (special && n < 4) return sp_exp[n];
    return base + n;
  endfunction

  // Full load: start, DEG beats, wait for load_done, then check every row
  task automatic run_load(input int base, input bit gap, input bit special,
                          input int restart_beat, input bit start_in_done,
                          input bit timing);
    int q0, d0, b0, rb0, s_cyc, nw;
    logic [DW-1:0] lane;
    q0 = wa_q.size(); d0 = done_q.size(); b0 = beats; rb0 = ready_bad;
    start = 1'b1; in_valid = 1'b0; s_cyc = cyc;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 0; n < DEG; n++) begin
      in_valid = 1'b1;
      in_data  = coef_in(n, base, special);
      start    = (n == restart_beat);
      @(posedge clk); #1; start = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    for (int i = 0; i < 40 && done_q.size() == d0; i++) @(negedge clk);
    check("load_done_count", done_q.size() - d0, 1);
    @(posedge clk); #1;
    check("busy_after_load", busy, 0);
    check("ready_in_load", ready_bad - rb0, 0);
    nw = wa_q.size() - q0;
    check("write_count", nw, MA);
    for (int k = 0; k < nw && k < MA; k++) begin
      check($sformatf("addr_%0d", k), wa_q[q0+k], k);
      check($sformatf("beats_before_write_%0d", k), wb_q[q0+k] - b0, BN*(k+1));
      for (int b = 0; b < BN; b++) begin
        lane = wd_q[q0+k][b*DW +: DW];
        check($sformatf("row%0d_lane%0d", k, b), lane, coef_exp(BN*k + b, base, special));
      end
    end
    if (timing && nw == MA && done_q.size() > d0) begin
      check("first_write_cycle", wc_q[q0] - s_cyc, 17);
      check("last_write_cycle", wc_q[q0+MA-1] - s_cyc, 1025);
      check("load_done_cycle", done_q[d0] - s_cyc, 1026);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int qa;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; modulus = 32'd65537;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_wr_addr", mem_wr_addr, 0);
    check("rst_wr_data_or", |mem_wr_data, 0);
    check("rst_load_done", load_done, 0);

    // Continuous stream, data = n
    run_load(0, 1'b0, 1'b0, -1, 1'b0, 1'b1);

    // Valid toggling 1,0,1,0
    run_load(0, 1'b1, 1'b0, -1, 1'b0, 1'b0);

    // Start pulses at beat 300 and during DONE are ignored
    run_load(100, 1'b0, 1'b0, 300, 1'b1, 1'b1);
    check("ready_after_ignored_start", in_ready, 0);

    // Reset at beat 500 aborts the load
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 0; n < 500; n++) begin
      in_valid = 1'b1; in_data = 9000 + n;
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 9500;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_wr_en", mem_wr_en, 0);
    check("abort_wr_addr", mem_wr_addr, 0);
    check("abort_wr_data_or", |mem_wr_data, 0);
    check("abort_load_done", load_done, 0);
    qa = wa_q.size();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_writes", wa_q.size() - qa, 0);
    run_load(5000, 1'b0, 1'b0, -1, 1'b0, 1'b1);

    // Valid in IDLE without start is ignored
    qa = wa_q.size();
    in_valid = 1'b1; in_data = 77;
    repeat (20) @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 0);
    check("idle_no_writes", wa_q.size() - qa, 0);
    in_valid = 1'b0;

    // Back-to-back loads; the second carries the reduction vectors
    run_load(200, 1'b0, 1'b0, -1, 1'b0, 1'b1);
    run_load(0, 1'b0, 1'b1, -1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
